// File: rtl/coreport_pkg.sv
// ---------------------------------------------------------------------------
// coreport_pkg
// Shared constants and types for the GPIO input-conditioning stage.
//   DEF_WIDTH / DEF_DIV_W / DEF_THRESH : default top-level parameter values
//   CNT_W                              : width of each pin's stability counter
//   pin_state_e                        : per-pin debounce state
// ---------------------------------------------------------------------------
package coreport_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DIV_W  = 16;
    localparam int DEF_THRESH = 4;
    localparam int CNT_W      = 4;

    // STABLE means the counter is zero; PENDING means a change is being qualified
    typedef enum logic {
        PIN_STABLE  = 1'b0,
        PIN_PENDING = 1'b1
    } pin_state_e;

endpackage

// File: rtl/gpio_debounce_cell.sv
// ---------------------------------------------------------------------------
// gpio_debounce_cell
// One pin: synchroniser chain, stability counter, level register and
// single-cycle edge pulses.
// Ports:
//   wb_clk, wb_rst : clock, synchronous active-high reset
//   pin_i          : raw asynchronous pad input
//   deb_en_i       : 1 = debounce against tick_i, 0 = bypass
//   tick_i         : shared prescaler tick
//   level_o        : conditioned level (registered)
//   rise_o, fall_o : one-cycle pulses coinciding with a new level_o value
//   reject_o       : (GPIO_DEBOUNCE_GLITCH_CNT_EN only) a pending change was
//                    abandoned this cycle without toggling the level
// ---------------------------------------------------------------------------
module gpio_debounce_cell
    import coreport_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   THRESH        = DEF_THRESH,
    parameter logic INITIAL_LEVEL = 1'b0
) (
    input  logic wb_clk,
    input  logic wb_rst,
    input  logic pin_i,
    input  logic deb_en_i,
    input  logic tick_i,
    output logic level_o,
    output logic rise_o,
`ifdef GPIO_DEBOUNCE_GLITCH_CNT_EN
    output logic reject_o,
`endif
    output logic fall_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(THRESH - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    pin_state_e             state_q, state_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Next-state: bypass copies the synchronised input; debounce only moves
    // the level after THRESH consecutive ticks of disagreement.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        level_d = level_q;
        if (!deb_en_i) begin
            level_d = s;
            cnt_d   = '0;
            state_d = PIN_STABLE;
        end else if (s == level_q) begin
            cnt_d   = '0;
            state_d = PIN_STABLE;
        end else if (tick_i) begin
            if (cnt_q == LAST_CNT) begin
                level_d = ~level_q;
                cnt_d   = '0;
                state_d = PIN_STABLE;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = PIN_PENDING;
            end
        end
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            sync_q  <= {SYNC_STAGES{INITIAL_LEVEL}};
            cnt_q   <= '0;
            state_q <= PIN_STABLE;
            level_q <= INITIAL_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_i};
            cnt_q   <= cnt_d;
            state_q <= state_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

`ifdef GPIO_DEBOUNCE_GLITCH_CNT_EN
    // Only an enabled pin falling back to agreement while PENDING is a glitch
    assign reject_o = deb_en_i && (state_q == PIN_PENDING) && (s == level_q);
`endif

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/gpio_debounce.sv
// ---------------------------------------------------------------------------
// gpio_debounce
// Input-conditioning stage between GPIO pads and the GPIO port input path.
// Holds the shared prescaler and one gpio_debounce_cell per pin.
// Ports:
//   wb_clk, wb_rst : clock, synchronous active-high reset
//   pin_i          : raw pad inputs
//   deb_en_i       : per-pin debounce enable (0 = bypass)
//   deb_div_i      : tick period minus one
//   level_o        : conditioned pin levels
//   rise_o, fall_o : per-pin single-cycle edge pulses
// Optional (macro GPIO_DEBOUNCE_GLITCH_CNT_EN):
//   glitch_clr_i   : clears the glitch counter (wins over increment)
//   glitch_cnt_o   : saturating count of cycles with at least one rejected glitch
// ---------------------------------------------------------------------------
module gpio_debounce
    import coreport_pkg::*;
#(
    parameter int               WIDTH         = DEF_WIDTH,
    parameter int               SYNC_STAGES   = 2,
    parameter int               DIV_W         = DEF_DIV_W,
    parameter int               THRESH        = DEF_THRESH,
    parameter logic [WIDTH-1:0] INITIAL_LEVEL = '0
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic [WIDTH-1:0] pin_i,
    input  logic [WIDTH-1:0] deb_en_i,
    input  logic [DIV_W-1:0] deb_div_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
`ifdef GPIO_DEBOUNCE_GLITCH_CNT_EN
    input  logic             glitch_clr_i,
    output logic [7:0]       glitch_cnt_o,
`endif
    output logic [WIDTH-1:0] fall_o
);

    logic [DIV_W-1:0] pre_q, pre_d;
    logic             tick;

    // The >= compare means lowering the divisor below the current count
    // still produces a tick on the very next cycle.
    always_comb begin
        tick  = (pre_q >= deb_div_i);
        pre_d = tick ? '0 : pre_q + DIV_W'(1);
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) pre_q <= '0;
        else        pre_q <= pre_d;
    end

`ifdef GPIO_DEBOUNCE_GLITCH_CNT_EN
    logic [WIDTH-1:0] reject;
`endif

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        gpio_debounce_cell #(
            .SYNC_STAGES  (SYNC_STAGES),
            .THRESH       (THRESH),
            .INITIAL_LEVEL(INITIAL_LEVEL[g])
        ) u_cell (
            .wb_clk  (wb_clk),
            .wb_rst  (wb_rst),
            .pin_i   (pin_i[g]),
            .deb_en_i(deb_en_i[g]),
            .tick_i  (tick),
            .level_o (level_o[g]),
            .rise_o  (rise_o[g]),
`ifdef GPIO_DEBOUNCE_GLITCH_CNT_EN
            .reject_o(reject[g]),
`endif
            .fall_o  (fall_o[g])
        );
    end

`ifdef GPIO_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_q, glitch_d;

    // Several pins rejecting in the same cycle count once; saturates at 255
    always_comb begin
        glitch_d = glitch_q;
        if (glitch_clr_i)
            glitch_d = '0;
        else if ((|reject) && (glitch_q != 8'hFF))
            glitch_d = glitch_q + 8'd1;
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) glitch_q <= '0;
        else        glitch_q <= glitch_d;
    end

    assign glitch_cnt_o = glitch_q;
`endif

endmodule
